// File: rtl/serial_load_pkg.sv
// Shared definitions for the serial capture controller: FSM encoding and counter sizing.
package serial_load_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_HOLD  = 2'b10
    } state_e;

    // Plain vector constants so the state register can hold the illegal 2'b11 code.
    localparam logic [STATE_W-1:0] ST_IDLE  = S_IDLE;
    localparam logic [STATE_W-1:0] ST_SHIFT = S_SHIFT;
    localparam logic [STATE_W-1:0] ST_HOLD  = S_HOLD;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/dff_en_sclr.sv
// Single D flip-flop with load enable and synchronous active-high clear (clear wins).
module dff_en_sclr (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/serial_load_ctrl.sv
// Serial-in/parallel-out capture: shifts WIDTH bits after a start, then presents the
// word with a valid/ack handshake and a sticky overrun flag for starts seen mid-shift.
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | sampling din once per edge, WIDTH edges total
// HOLD   | word presented on q, waiting for q_ack
module serial_load_ctrl
    import serial_load_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             din,
    input  logic             q_ack,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic             ovr
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_q_valid;
    logic               r_ovr;

    logic [WIDTH-1:0]   w_sr;
    logic [WIDTH-1:0]   w_sr_next;
    logic               w_illegal;
    logic               w_chain_clr;
    logic               w_shift_en;
    logic               w_done;

    assign w_illegal   = (r_state != ST_IDLE) && (r_state != ST_SHIFT) && (r_state != ST_HOLD);
    assign w_chain_clr = clr | w_illegal;
    assign w_shift_en  = (r_state == ST_SHIFT);
    assign w_done      = w_shift_en && (r_cnt == CNT_LAST);

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sr_next = {w_sr[WIDTH-2:0], din};
        end else begin : g_lsb_first
            assign w_sr_next = {din, w_sr[WIDTH-1:1]};
        end
    endgenerate

    // The output bank loads the chain's next value so q includes the final bit directly.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bank
            dff_en_sclr u_sr_bit (
                .i_clk (clk),
                .i_clr (w_chain_clr),
                .i_en  (w_shift_en),
                .i_d   (w_sr_next[gi]),
                .o_q   (w_sr[gi])
            );

            dff_en_sclr u_q_bit (
                .i_clk (clk),
                .i_clr (w_chain_clr),
                .i_en  (w_done),
                .i_d   (w_sr_next[gi]),
                .o_q   (q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_q_valid <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (start) begin
                        r_ovr <= 1'b1;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_HOLD;
                        r_q_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (q_ack) begin
                        r_q_valid <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= start ? ST_SHIFT : ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_q_valid <= 1'b0;
                    r_ovr     <= 1'b0;
                end
            endcase
        end
    end

    assign q_valid = r_q_valid;
    assign ovr     = r_ovr;
    assign busy    = (r_state == ST_SHIFT) || (r_state == ST_HOLD);

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Scoreboard bench for serial_load_ctrl: MSB-first and LSB-first instances share stimulus.
module tb_serial_load_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         clr   = 1'b1;
    logic         start = 1'b0;
    logic         din   = 1'b0;
    logic         q_ack = 1'b0;

    logic [W-1:0] q_m, q_l;
    logic         qv_m, qv_l, busy_m, busy_l, ovr_m, ovr_l;

    always #5 clk = ~clk;

    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .clr(clr), .start(start), .din(din), .q_ack(q_ack),
        .q(q_m), .q_valid(qv_m), .busy(busy_m), .ovr(ovr_m)
    );

    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .clr(clr), .start(start), .din(din), .q_ack(q_ack),
        .q(q_l), .q_valid(qv_l), .busy(busy_l), .ovr(ovr_l)
    );

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] exp_m[$];
    logic [W-1:0] exp_l[$];
    bit           mon_en   = 1'b0;
    bit           clr_last = 1'b0;
    bit           mon_pv   = 1'b0;
    logic [W-1:0] mon_pq_m = '0;
    logic [W-1:0] mon_pq_l = '0;
    bit           exp_ovr  = 1'b0;
    bit           in_hold  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // seq is written in arrival order: seq[W-1] is the first bit on din.
    function automatic logic [W-1:0] model_word(input logic [W-1:0] seq, input bit msb_first);
        int acc;
        int b;
        acc = 0;
        for (int j = 0; j < W; j++) begin
            b = int'(seq[W-1-j]);
            if (msb_first) acc = acc * 2 + b;
            else           acc = acc + (b << j);
        end
        return W'(acc);
    endfunction

    // Starts from IDLE (via_ack=0) or from HOLD with a same-edge ack (via_ack=1).
    task automatic capture(input logic [W-1:0] seq, input int ovr_edge, input bit via_ack);
        logic [W-1:0] held_m;
        int           low_cnt;
        held_m = q_m;
        exp_m.push_back(model_word(seq, 1'b1));
        exp_l.push_back(model_word(seq, 1'b0));
        start = 1'b1;
        q_ack = via_ack;
        step();
        start   = 1'b0;
        q_ack   = 1'b0;
        low_cnt = 0;
        if (!qv_m) low_cnt++;
        chk("busy after start", {31'd0, busy_m}, 32'd1);
        for (int j = 0; j < W; j++) begin
            din   = seq[W-1-j];
            start = (ovr_edge == j + 1);
            if (start) exp_ovr = 1'b1;
            q_ack = 1'($urandom_range(0, 1));
            step();
            if (j < W - 1 && !qv_m) low_cnt++;
            if (j == W - 2 && via_ack) chk("q held during back-to-back", {24'd0, q_m}, {24'd0, held_m});
        end
        start = 1'b0;
        q_ack = 1'b0;
        din   = 1'($urandom_range(0, 1));
        chk("q_valid msb after word", {31'd0, qv_m}, 32'd1);
        chk("q_valid lsb after word", {31'd0, qv_l}, 32'd1);
        chk("busy in hold", {31'd0, busy_l}, 32'd1);
        chk("q_valid low cycles", low_cnt, W);
        chk("ovr msb", {31'd0, ovr_m}, {31'd0, exp_ovr});
        chk("ovr lsb", {31'd0, ovr_l}, {31'd0, exp_ovr});
        in_hold = 1'b1;
    endtask

    task automatic release_word(input int wait_cycles);
        logic [W-1:0] held;
        held = q_m;
        for (int i = 0; i < wait_cycles; i++) begin
            start = 1'($urandom_range(0, 1));
            din   = 1'($urandom_range(0, 1));
            step();
            chk("hold q_valid", {31'd0, qv_m}, 32'd1);
        end
        start = 1'b0;
        q_ack = 1'b1;
        step();
        q_ack = 1'b0;
        chk("q_valid after ack", {31'd0, qv_m}, 32'd0);
        chk("busy after ack", {31'd0, busy_m}, 32'd0);
        chk("q retained after ack", {24'd0, q_m}, {24'd0, held});
        chk("ovr after hold", {31'd0, ovr_m}, {31'd0, exp_ovr});
        in_hold = 1'b0;
    endtask

    task automatic do_clr();
        clr   = 1'b1;
        start = 1'($urandom_range(0, 1));
        q_ack = 1'($urandom_range(0, 1));
        din   = 1'($urandom_range(0, 1));
        step();
        clr     = 1'b0;
        start   = 1'b0;
        q_ack   = 1'b0;
        exp_ovr = 1'b0;
        in_hold = 1'b0;
        chk("clr q msb", {24'd0, q_m}, 32'd0);
        chk("clr q lsb", {24'd0, q_l}, 32'd0);
        chk("clr q_valid", {31'd0, qv_m}, 32'd0);
        chk("clr busy", {31'd0, busy_m}, 32'd0);
        chk("clr ovr", {31'd0, ovr_m}, 32'd0);
    endtask

    always @(posedge clk) clr_last = clr;

    // Pops the scoreboard on every rising q_valid; any other q change must come from clr.
    always @(negedge clk) begin
        if (mon_en) begin
            if (qv_m && !mon_pv) begin
                if (exp_m.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected word: actual=%0h required=none", q_m);
                end else begin
                    chk("word msb_first", {24'd0, q_m}, {24'd0, exp_m.pop_front()});
                    chk("word lsb_first", {24'd0, q_l}, {24'd0, exp_l.pop_front()});
                end
            end else if (!clr_last) begin
                if (q_m !== mon_pq_m) chk("q msb stable", {24'd0, q_m}, {24'd0, mon_pq_m});
                if (q_l !== mon_pq_l) chk("q lsb stable", {24'd0, q_l}, {24'd0, mon_pq_l});
            end
            mon_pv   = qv_m;
            mon_pq_m = q_m;
            mon_pq_l = q_l;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] seq;
        int           ovr_edge;
        int           idle_cycles;

        clr   = 1'b1;
        start = 1'b1;
        din   = 1'b1;
        step();
        step();
        chk("reset q msb", {24'd0, q_m}, 32'd0);
        chk("reset q lsb", {24'd0, q_l}, 32'd0);
        chk("reset q_valid", {31'd0, qv_m}, 32'd0);
        chk("reset busy", {31'd0, busy_m}, 32'd0);
        chk("reset ovr", {31'd0, ovr_m}, 32'd0);
        clr   = 1'b0;
        start = 1'b0;
        din   = 1'b0;
        step();
        chk("idle after release busy", {31'd0, busy_m}, 32'd0);
        chk("idle after release q_valid", {31'd0, qv_l}, 32'd0);
        mon_pq_m = q_m;
        mon_pq_l = q_l;
        mon_en   = 1'b1;

        capture(8'hB2, 0, 1'b0);
        release_word(3);

        capture(8'hB2, 3, 1'b0);
        capture(8'hFF, 0, 1'b1);
        release_word(0);

        do_clr();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            din = 1'($urandom_range(0, 1));
            step();
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        exp_ovr = 1'b0;
        chk("abort q", {24'd0, q_m}, 32'd0);
        chk("abort busy", {31'd0, busy_m}, 32'd0);
        chk("abort q_valid", {31'd0, qv_m}, 32'd0);
        capture(8'h3C, 0, 1'b0);
        release_word(1);

        repeat (25) begin
            if ($urandom_range(0, 9) == 0) do_clr();
            seq      = W'($urandom);
            ovr_edge = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
            if (in_hold && $urandom_range(0, 1) == 1) begin
                capture(seq, ovr_edge, 1'b1);
            end else begin
                if (in_hold) release_word(int'($urandom_range(0, 3)));
                idle_cycles = int'($urandom_range(0, 2));
                for (int i = 0; i < idle_cycles; i++) begin
                    din   = 1'($urandom_range(0, 1));
                    q_ack = 1'($urandom_range(0, 1));
                    step();
                    q_ack = 1'b0;
                end
                capture(seq, ovr_edge, 1'b0);
            end
        end
        if (in_hold) release_word(0);
        step();
        step();
        chk("scoreboard drained", exp_m.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
